// File: rtl/uart_bus_responder.sv
`default_nettype none
// uart_bus_responder: memory-mapped 8N1 UART with a TX FIFO that stalls CPU stores when full.
// Define UART_RX_EN to include the receiver; without it the receive fields read as zero.
module uart_bus_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0080_0000,
  parameter int          CLKS_PER_BIT = 217,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_rbusy,
  output logic        mem_wbusy,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic       hit, store, rd_data, rd_stat;
  logic [1:0] sel;
  assign hit     = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign sel     = mem_addr[3:2];
  assign store   = hit && (sel == 2'd0) && mem_wmask[0];
  assign rd_data = hit && mem_rstrb && (sel == 2'd0);
  assign rd_stat = hit && mem_rstrb && (sel == 2'd1);

  logic [7:0]  fifo_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, count;
  logic        tx_empty, tx_full, push, pop;
  logic [7:0]  push_data, fifo_head;
  logic        pend_q, pend_d;
  logic [7:0]  pend_data_q, pend_data_d;
  assign count     = wr_ptr_q - rd_ptr_q;
  assign tx_empty  = (count == '0);
  assign tx_full   = (count == DEPTH);
  assign fifo_head = fifo_q[rd_ptr_q[AW-1:0]];
  assign mem_wbusy = pend_q;
  assign mem_rbusy = 1'b0;

  // A stalled byte always drains before any new store is accepted, keeping order.
  always_comb begin
    push        = 1'b0;
    push_data   = mem_wdata[7:0];
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    if (pend_q) begin
      if (!tx_full) begin
        push      = 1'b1;
        push_data = pend_data_q;
        pend_d    = 1'b0;
      end
    end else if (store) begin
      if (!tx_full) begin
        push = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_data_d = mem_wdata[7:0];
      end
    end
  end

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;
  assign uart_tx = tx_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    pop        = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (!tx_empty) begin
        pop        = 1'b1;
        tx_shift_d = fifo_head;
        tx_cnt_d   = '0;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      TX_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      TX_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_head;
          tx_state_d = TX_START;
        end else tx_state_d = TX_IDLE;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  logic [7:0] rx_byte;
  logic       rx_valid, overrun, ferr;

`ifdef UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  localparam logic [CW-1:0] RX_MID = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     rx_state_q, rx_state_d;
  logic [2:0]    rx_sync_q;  // [1] is the synchronised line, [2] its previous value
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d, overrun_q, overrun_d, ferr_q, ferr_d;
  logic          rx_line, frame_ok, frame_bad, valid_kept;
  assign rx_line  = rx_sync_q[1];
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign ferr     = ferr_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_sync_q[2] && !rx_line) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == RX_MID) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_line ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_line, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        else rx_bit_d = rx_bit_q + 1'b1;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_state_d = RX_IDLE;
        frame_ok   = rx_line;
        frame_bad  = !rx_line;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      default: rx_state_d = RX_IDLE;
    endcase
    // A DATA read in the same cycle as a new byte counts as consumed first.
    valid_kept = rx_valid_q & ~rd_data;
    rx_valid_d = valid_kept;
    rx_byte_d  = rx_byte_q;
    overrun_d  = overrun_q & ~rd_stat;
    ferr_d     = ferr_q & ~rd_stat;
    if (frame_ok) begin
      if (valid_kept) overrun_d = 1'b1;
      else begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end
    if (frame_bad) ferr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_sync_q  <= 3'b111;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sync_q  <= {rx_sync_q[1:0], uart_rx};
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end
`else
  logic unused_rx;
  assign unused_rx = uart_rx ^ rd_data ^ rd_stat;
  assign rx_byte   = 8'h00;
  assign rx_valid  = 1'b0;
  assign overrun   = 1'b0;
  assign ferr      = 1'b0;
`endif

  logic unused_bus;
  assign unused_bus = ^{mem_addr[1:0], mem_wdata[31:8], mem_wmask[3:1]};

  logic [31:0] rdata_q, rdata_d;
  assign mem_rdata = rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (mem_rstrb) begin
      rdata_d = '0;
      if (hit) begin
        case (sel)
          2'd0:    rdata_d = {24'h0, rx_byte};
          2'd1:    rdata_d = {27'h0, ferr, overrun, rx_valid, tx_full, tx_empty};
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      rdata_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_q + (AW+1)'(push);
      rd_ptr_q    <= rd_ptr_q + (AW+1)'(pop);
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
      rdata_q     <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= push_data;
  end
endmodule
`default_nettype wire
